// File: rtl/vend_status_if.sv
// Status-transmitter bus: request strobes and credit in, serial line and status out.
// report/dispensed are one-cycle requests that are always accepted (no ready); done is a one-cycle completion pulse.
interface vend_status_if;
  logic [4:0] credit;
  logic       report;
  logic       dispensed;
  logic       TxD;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  modport master (
    output credit, report, dispensed,
    input  TxD, busy, done, state_dbg
  );

  modport slave (
    input  credit, report, dispensed,
    output TxD, busy, done, state_dbg
  );
endinterface

// File: rtl/vend_status_tx.sv
// UART transmitter sending "C<tens><ones>\r\n" / "W<tens><ones>\r\n" status messages.
// Optional even-parity bit between data bit 7 and the stop bit when UART_TX_PARITY_EN is defined.
module vend_status_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input  logic          clk,
  input  logic          reset,
  vend_status_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, NEXT = 3'd4, PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, NEXT = 3'd4
  } state_t;
`endif

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // The stop bit's final cycle is spent in NEXT, so consecutive bytes have no gap.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic             msg_disp;
  logic [4:0]       credit_hold;
  logic             pend_report, pend_dispense;
  logic             done_q;
  logic             eff_report, eff_disp, start_msg, bit_done;
  logic [3:0]       tens, ones;
  logic [7:0]       cur_byte;
  logic             tx;

  // A strobe in the same cycle as the idle check starts the message immediately.
  assign eff_report = pend_report | bus.report;
  assign eff_disp   = pend_dispense | bus.dispensed;
  assign start_msg  = (state == IDLE) && (eff_report || eff_disp);
  assign bit_done   = (cnt == BIT_LAST);

  always_comb begin
    if (credit_hold >= 5'd30)      tens = 4'd3;
    else if (credit_hold >= 5'd20) tens = 4'd2;
    else if (credit_hold >= 5'd10) tens = 4'd1;
    else                           tens = 4'd0;
    ones = 4'(credit_hold - 5'(tens) * 5'd10);
  end

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = msg_disp ? 8'h57 : 8'h43;
      3'd1:    cur_byte = {4'h3, tens};
      3'd2:    cur_byte = {4'h3, ones};
      3'd3:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_msg) state_nxt = START;
      START: if (bit_done) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (bit_done) state_nxt = STOP;
`else
      DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (cnt == STOP_LAST) state_nxt = NEXT;
      NEXT:  state_nxt = (byte_idx == 3'd4) ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = ^cur_byte;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign bus.TxD       = tx;
  assign bus.busy      = (state != IDLE) | pend_report | pend_dispense;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      msg_disp      <= 1'b0;
      credit_hold   <= '0;
      pend_report   <= 1'b0;
      pend_dispense <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // Dispense wins when both are pending; the loser stays latched.
      pend_dispense <= eff_disp & ~start_msg;
      pend_report   <= eff_report & ~(start_msg & ~eff_disp);
      done_q        <= (state == NEXT) && (byte_idx == 3'd4);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_msg) begin
            credit_hold <= bus.credit;
            msg_disp    <= eff_disp;
            byte_idx    <= '0;
          end
        end
        START: begin
          bit_idx <= '0;
          cnt     <= bit_done ? '0 : cnt + CNT_W'(1);
        end
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: cnt <= bit_done ? '0 : cnt + CNT_W'(1);
`endif
        STOP: cnt <= (cnt == STOP_LAST) ? '0 : cnt + CNT_W'(1);
        NEXT: begin
          cnt      <= '0;
          byte_idx <= byte_idx + 3'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_status_tx.sv
// Bench for vend_status_tx: message-level timing model, per-cycle status checks
// and a UART receiver feeding a byte scoreboard.
module tb_vend_status_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int MSG_CYC = 5 * FRAME * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vend_status_if bus();

  vend_status_tx #(.CLKS_PER_BIT(CPB), .CNT_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model state: a message started at cycle s occupies cycles s+1..s+MSG_CYC.
  int   cyc = 0;
  int   last_busy = -1;
  bit   p_r = 0, p_d = 0;
  bit   exp_busy = 0, exp_done = 0;
  bit   rx_act = 0;
  int   rx_off = 0;
  int   bit_no = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] got_byte = 8'h00;
  logic [4:0] cr = 5'd0;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_txd", bus.TxD, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      p_r = 0; p_d = 0; last_busy = -1;
      exp_busy = 0; exp_done = 0; rx_act = 0;
      exp_q.delete();
    end else begin
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, exp_done);
      if (cyc > last_busy) check("idle_txd", bus.TxD, 1);

      if (!rx_act) begin
        if (bus.TxD == 1'b0) begin
          rx_act = 1;
          rx_off = 0;
        end
      end else begin
        rx_off++;
      end
      if (rx_act && (rx_off % CPB == CPB / 2)) begin
        bit_no = rx_off / CPB;
        if (bit_no == 0) begin
          check("start_bit", bus.TxD, 0);
        end else if (bit_no <= 8) begin
          rx_byte[bit_no-1] = bus.TxD;
        end else if (bit_no == FRAME - 1) begin
          check("stop_bit", bus.TxD, 1);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(rx_byte), -1);
          end else begin
            got_byte = exp_q.pop_front();
            check("rx_byte", int'(rx_byte), int'(got_byte));
          end
          rx_act = 0;
        end else begin
          check("parity_bit", bus.TxD, int'(^rx_byte));
        end
      end

      exp_done = (cyc == last_busy);
      if (bus.report)    p_r = 1;
      if (bus.dispensed) p_d = 1;
      if (cyc > last_busy && (p_r || p_d)) begin
        cr = bus.credit;
        exp_q.push_back(p_d ? 8'h57 : 8'h43);
        exp_q.push_back(8'h30 + 8'(cr / 10));
        exp_q.push_back(8'h30 + 8'(cr % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        if (p_d) p_d = 0;
        else     p_r = 0;
        last_busy = cyc + MSG_CYC;
      end
      exp_busy = (cyc + 1 <= last_busy) || p_r || p_d;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit r, input bit d);
    bus.report    = r;
    bus.dispensed = d;
    tick();
    bus.report    = 1'b0;
    bus.dispensed = 1'b0;
  endtask

  initial begin
    int guard;
    bus.credit    = 5'd0;
    bus.report    = 1'b0;
    bus.dispensed = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    tick();

    // Credit report, credit 15
    bus.credit = 5'd15;
    pulse(1, 0);
    wait_cycles(MSG_CYC + 10);

    // Dispense report, credit 0
    bus.credit = 5'd0;
    pulse(0, 1);
    wait_cycles(MSG_CYC + 10);

    // Both at once: dispense first, then credit report
    bus.credit = 5'd7;
    pulse(1, 1);
    wait_cycles(2 * MSG_CYC + 20);

    // Repeated reports coalesce; credit change affects only the later message
    bus.credit = 5'd12;
    pulse(1, 0);
    wait_cycles(20);
    pulse(1, 0);
    wait_cycles(30);
    bus.credit = 5'd31;
    pulse(1, 0);
    wait_cycles(10);
    pulse(1, 0);
    wait_cycles(2 * MSG_CYC + 20);

    // Reset during data bit 3 of byte 2
    bus.credit = 5'd22;
    pulse(1, 0);
    wait_cycles(2 * FRAME * CPB + 4 * CPB + 1);
    #2 reset = 1'b1;
    #1;
    check("abort_txd", bus.TxD, 1);
    check("abort_busy", bus.busy, 0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(60);

    // Randomised strobes, credits and gaps
    for (int i = 0; i < 40; i++) begin
      bus.credit = 5'($urandom_range(0, 31));
      pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) bus.credit = 5'($urandom_range(0, 31));
      wait_cycles($urandom_range(0, 300));
    end

    guard = 0;
    while ((exp_q.size() != 0 || bus.busy || cyc <= last_busy + 2) && guard < 3000) begin
      tick();
      guard++;
    end
    check("drain_timeout", (guard < 3000) ? 1 : 0, 1);
    check("drain_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_status_tx.md
Name: vend_status_tx

Overview:
UART transmitter that returns vending-machine status to the host PC over TxD. It is the reverse path to the character receivers that decode a/b/c/s/r commands. On request it serialises an ASCII status message. The message carries the current credit as two decimal digits, and also reports a dispense event. It runs on the fast system clock alongside the FSM and sits between the FSM outputs and the board TxD pin.

Parameters:
CLKS_PER_BIT, 10417, system clocks per UART bit (100 MHz / 9600 baud); must be >= 2
CNT_W, 14, width of the bit-period counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
credit  input  5  current credit from fsm, binary 0..31
report  input  1  one-cycle strobe: send credit report
dispensed  input  1  one-cycle strobe: water dispensed, send dispense report
TxD  output  1  serial line, idle high
busy  output  1  high while a message is in progress or pending
done  output  1  one-cycle pulse after the final stop bit of a message

Behaviour:
- Reset values: TxD=1, busy=0, done=0, state=IDLE, pending flags cleared. Reset asserted mid-frame aborts immediately (TxD=1 asynchronously); no partial byte resumes.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles; no idle gap between bytes of one message.
- Messages:
  - Credit report: 'C'(0x43), tens digit, ones digit, 0x0D, 0x0A (5 bytes).
  - Dispense report: 'W'(0x57), tens digit, ones digit, 0x0D, 0x0A (5 bytes); digits are the credit remaining after dispense.
- Digits: tens = credit/10, ones = credit%10, each ASCII-encoded as 0x30+d; credit 31 -> "31"; credit 0 -> "00".
- credit is sampled into a holding register in the cycle the message starts (IDLE->START), not at strobe time; later changes do not affect a message in flight.
- FSM states: IDLE, START, DATA, STOP, NEXT.
  - IDLE: go to START when any pending flag is set.
  - START, DATA and STOP each last CLKS_PER_BIT per bit; DATA shifts bit_idx 0..7.
  - NEXT: advances byte_idx 0..4; after byte 4 it returns to IDLE and pulses done.
- Latency: strobe at cycle n with the transmitter idle -> TxD falls at cycle n+1 and busy=1 from n+1.
- Pending: a strobe sets pend_report or pend_dispense; strobes arriving while busy are latched (single-deep per type). Repeats of the same type coalesce.
- Priority: when both are pending at message start, the dispense message goes first, then the credit report back-to-back. A strobe arriving in the same cycle the FSM leaves IDLE is retained.
- busy = (state != IDLE) | pend_report | pend_dispense.

Optional Feature:
UART_TX_PARITY_EN: when defined, an even-parity bit is inserted between data bit 7 and the stop bit (11-bit frame, parity = XOR of the 8 data bits). When undefined, the frame is 10 bits with no parity state; port list is unchanged.

Test Plan:
- CLKS_PER_BIT=4, credit=15, report pulse -> TxD sends 0x43,0x31,0x35,0x0D,0x0A; each bit 4 clocks; message 200 clocks; done pulses once at clock 201.
- credit=0, dispensed pulse -> bytes 0x57,0x30,0x30,0x0D,0x0A; busy high for the whole message, low after done.
- report and dispensed in the same cycle with credit=7 -> "W07\r\n" then "C07\r\n" back-to-back; done pulses twice.
- Three report pulses during a message in flight -> exactly one additional "C" message follows; credit changed 12->31 mid-message -> first message shows "12", second "31".
- Reset asserted during data bit 3 of byte 2 -> TxD=1 and busy=0 immediately; after release, no further output without a new strobe.
- With UART_TX_PARITY_EN defined, byte 0x43 -> parity bit 1, frame 11 bits; byte 0x30 -> parity bit 0.
